// File: rtl/io_input_port_pkg.sv
// Shared definitions for the external input channel reader.
//   IO_WIDTH        data word width
//   IO_FIFO_DEPTH   number of buffered words (power of two, >= 2)
//   IO_EMPTY_VALUE  value returned by a read that finds the FIFO empty
//   io_log2()       ceiling log2, sizes pointers and the word counter
package io_input_port_pkg;

  localparam int unsigned IO_WIDTH       = 16;
  localparam int unsigned IO_FIFO_DEPTH  = 4;
  localparam logic [15:0] IO_EMPTY_VALUE = 16'h0000;

  // Ceiling log2; a fixed-bound loop keeps it usable in constant contexts.
  function automatic int unsigned io_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/io_input_port_fifo_mem.sv
// io_fifo_mem: DEPTH x WIDTH register array backing the input FIFO.
//   CLK     rising-edge clock
//   WrEn    write strobe; WrData is stored at WrAddr on the edge
//   WrAddr  write address
//   WrData  write data
//   RdAddr  read address (combinational read)
//   RdData  contents of the addressed entry
// Contents are not reset; the owner tracks which entries are valid.
module io_fifo_mem
  import io_input_port_pkg::*;
#(
  parameter int unsigned WIDTH = IO_WIDTH,
  parameter int unsigned DEPTH = IO_FIFO_DEPTH
) (
  input  logic                      CLK,
  input  logic                      WrEn,
  input  logic [io_log2(DEPTH)-1:0] WrAddr,
  input  logic [WIDTH-1:0]          WrData,
  input  logic [io_log2(DEPTH)-1:0] RdAddr,
  output logic [WIDTH-1:0]          RdData
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (WrEn) mem_d[WrAddr] = WrData;
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign RdData = mem_q[RdAddr];

endmodule

// File: rtl/io_input_port.sv
// io_input_port: processor-side reader for the external 16-bit input channel.
// The device pushes words with a valid/ready handshake into a small FIFO; the
// control unit pops them with ReadEn and gets a registered ReadData one cycle
// later.
//   CLK        rising-edge clock
//   Reset      asynchronous, active-low reset
//   DevData    word offered by the device
//   DevValid   device has a word on DevData
//   DevReady   FIFO can accept a word (not full)
//   ReadEn     read strobe, one word per asserted cycle
//   ReadData   registered read result
//   ReadValid  one-cycle pulse: ReadData holds a real FIFO word
//   Empty      no words held
//   Full       DEPTH words held
//   Count      number of words held
//   Underflow  sticky: a read happened while empty
//   ClearErr   synchronous clear of Underflow
module io_input_port
  import io_input_port_pkg::*;
#(
  parameter int unsigned      WIDTH       = IO_WIDTH,
  parameter int unsigned      DEPTH       = IO_FIFO_DEPTH,
  parameter logic [WIDTH-1:0] EMPTY_VALUE = WIDTH'(IO_EMPTY_VALUE)
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic [WIDTH-1:0]        DevData,
  input  logic                    DevValid,
  output logic                    DevReady,
  input  logic                    ReadEn,
  output logic [WIDTH-1:0]        ReadData,
  output logic                    ReadValid,
  output logic                    Empty,
  output logic                    Full,
  output logic [io_log2(DEPTH):0] Count,
  output logic                    Underflow,
  input  logic                    ClearErr
);

  localparam int unsigned AW = io_log2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             underflow_q, underflow_d;

  logic             empty, full;
  logic             push, pop, under;
  logic [WIDTH-1:0] mem_rdata;

  // Flags come from the registered count only, never from this cycle's strobes.
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  assign push  = DevValid & ~full;
  assign pop   = ReadEn & ~empty;
  assign under = ReadEn & empty;

  io_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .CLK    (CLK),
    .WrEn   (push),
    .WrAddr (wptr_q),
    .WrData (DevData),
    .RdAddr (rptr_q),
    .RdData (mem_rdata)
  );

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // An empty read reloads the hold register with EMPTY_VALUE; an idle cycle
  // keeps the last value.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = pop;
    if (pop) begin
      rdata_d = mem_rdata;
    end else if (under) begin
      rdata_d = EMPTY_VALUE;
    end
  end

  // A fresh underflow takes priority over ClearErr in the same cycle.
  always_comb begin
    underflow_d = underflow_q;
    if (under) begin
      underflow_d = 1'b1;
    end else if (ClearErr) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rdata_q     <= EMPTY_VALUE;
      rvalid_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      underflow_q <= underflow_d;
    end
  end

  assign DevReady  = ~full;
  assign Empty     = empty;
  assign Full      = full;
  assign Count     = count_q;
  assign ReadData  = rdata_q;
  assign ReadValid = rvalid_q;
  assign Underflow = underflow_q;

endmodule

// File: tb/tb_io_input_port.sv
// Directed bench for io_input_port with a queue-based reference model and a
// scoreboard of expected read words.
module tb_io_input_port;

  localparam int unsigned DEPTH = 4;

  logic        CLK;
  logic        Reset;
  logic [15:0] DevData;
  logic        DevValid;
  logic        DevReady;
  logic        ReadEn;
  logic [15:0] ReadData;
  logic        ReadValid;
  logic        Empty;
  logic        Full;
  logic [2:0]  Count;
  logic        Underflow;
  logic        ClearErr;

  io_input_port dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .DevData   (DevData),
    .DevValid  (DevValid),
    .DevReady  (DevReady),
    .ReadEn    (ReadEn),
    .ReadData  (ReadData),
    .ReadValid (ReadValid),
    .Empty     (Empty),
    .Full      (Full),
    .Count     (Count),
    .Underflow (Underflow),
    .ClearErr  (ClearErr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] mq[$];      // model FIFO contents
  logic [15:0] exp_q[$];   // scoreboard: words expected on ReadData
  logic        m_under = 1'b0;
  logic [15:0] m_last  = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags();
    chk("count",     32'(Count),     32'(mq.size()));
    chk("empty",     32'(Empty),     32'(mq.size() == 0));
    chk("full",      32'(Full),      32'(mq.size() == DEPTH));
    chk("devready",  32'(DevReady),  32'(mq.size() != DEPTH));
    chk("underflow", 32'(Underflow), 32'(m_under));
  endtask

  // One clock: drive inputs, predict, step past the edge, compare.
  task automatic cycle(input logic dv, input logic [15:0] dd, input logic re, input logic ce);
    logic m_push, m_pop, m_und;
    logic [15:0] e;
    DevValid = dv;
    DevData  = dd;
    ReadEn   = re;
    ClearErr = ce;
    m_push = dv && (mq.size() < DEPTH);
    m_pop  = re && (mq.size() > 0);
    m_und  = re && (mq.size() == 0);
    if (m_pop) begin
      exp_q.push_back(mq[0]);
      void'(mq.pop_front());
    end
    if (m_push) mq.push_back(dd);
    if (m_und) m_under = 1'b1;
    else if (ce) m_under = 1'b0;
    @(posedge CLK);
    #1;
    if (m_pop) begin
      e = exp_q.pop_front();
      chk("rdata", 32'(ReadData), 32'(e));
      chk("rvalid", 32'(ReadValid), 32'd1);
      m_last = e;
    end else if (m_und) begin
      chk("rdata_empty", 32'(ReadData), 32'h0000);
      chk("rvalid_empty", 32'(ReadValid), 32'd0);
      m_last = 16'h0000;
    end else begin
      chk("rdata_hold", 32'(ReadData), 32'(m_last));
      chk("rvalid_idle", 32'(ReadValid), 32'd0);
    end
    chk_flags();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_count"},  32'(Count),     32'd0);
    chk({tag, "_empty"},  32'(Empty),     32'd1);
    chk({tag, "_full"},   32'(Full),      32'd0);
    chk({tag, "_ready"},  32'(DevReady),  32'd1);
    chk({tag, "_rdata"},  32'(ReadData),  32'h0000);
    chk({tag, "_rvalid"}, 32'(ReadValid), 32'd0);
    chk({tag, "_under"},  32'(Underflow), 32'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_under = 1'b0;
    m_last  = 16'h0000;
  endtask

  initial begin
    Reset    = 1'b0;
    DevData  = '0;
    DevValid = 1'b0;
    ReadEn   = 1'b0;
    ClearErr = 1'b0;
    #2;
    reset_checks("por");
    @(negedge CLK);
    Reset = 1'b1;

    // In-order reads of three words, then empty.
    cycle(1, 16'h1111, 0, 0);
    cycle(1, 16'h2222, 0, 0);
    cycle(1, 16'h3333, 0, 0);
    cycle(0, 16'h0000, 1, 0);
    cycle(0, 16'h0000, 1, 0);
    cycle(0, 16'h0000, 1, 0);
    cycle(0, 16'h0000, 0, 0);

    // Fill to full, hold the fifth word, read one, accept it, drain with wrap.
    cycle(1, 16'hA001, 0, 0);
    cycle(1, 16'hA002, 0, 0);
    cycle(1, 16'hA003, 0, 0);
    cycle(1, 16'hA004, 0, 0);
    cycle(1, 16'hA005, 0, 0);
    cycle(1, 16'hA005, 1, 0);
    cycle(1, 16'hA005, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 16'h0000, 1, 0);
    cycle(0, 16'h0000, 0, 0);

    // Steady state at Count=2 with simultaneous push and pop.
    cycle(1, 16'hC000, 0, 0);
    cycle(1, 16'hC001, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 16'hC002 + 16'(i), 1, 0);
    cycle(0, 16'h0000, 1, 0);
    cycle(0, 16'h0000, 1, 0);

    // Underflow, clear, and clear colliding with a new underflow.
    cycle(0, 16'h0000, 1, 0);
    cycle(0, 16'h0000, 0, 1);
    cycle(0, 16'h0000, 1, 1);
    cycle(0, 16'h0000, 0, 1);

    // Empty read with a simultaneous push: no bypass.
    cycle(1, 16'hBEEF, 1, 0);
    cycle(0, 16'h0000, 1, 0);
    cycle(0, 16'h0000, 0, 0);

    // Asynchronous reset mid-burst with three words buffered.
    cycle(1, 16'hD001, 0, 0);
    cycle(1, 16'hD002, 0, 0);
    cycle(1, 16'hD003, 1, 1);
    cycle(1, 16'hD004, 0, 0);
    chk("pre_reset_count", 32'(Count), 32'd3);
    Reset    = 1'b0;
    DevValid = 1'b0;
    ReadEn   = 1'b0;
    ClearErr = 1'b0;
    #1;
    reset_checks("async");
    model_reset();
    #1;
    Reset = 1'b1;
    cycle(0, 16'h0000, 0, 0);
    cycle(1, 16'hE123, 0, 0);
    cycle(0, 16'h0000, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_input_port.md
Name: io_input_port

Overview:
- Processor-side reader for the 16-bit external input channel of the accumulator datapath.
- An external device writes words in with a valid/ready handshake; the block buffers them in a small FIFO.
- The control unit pulls words out with a read strobe; ReadData is registered and feeds the datapath's input mux.
- It is the consumer end of the device write interface; a ReadData hold with reload is the read-side counterpart of a write-enabled register.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- EMPTY_VALUE, 16'h0000, value loaded into ReadData when a read hits an empty FIFO.

Ports:
- CLK  input  1  single rising-edge clock.
- Reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- DevData  input  WIDTH  word offered by the external device.
- DevValid  input  1  device has a word on DevData.
- DevReady  output  1  block can accept a word this cycle.
- ReadEn  input  1  control-unit read strobe; one word per asserted cycle.
- ReadData  output  WIDTH  registered read result.
- ReadValid  output  1  one-cycle pulse: ReadData holds a real FIFO word.
- Empty  output  1  FIFO holds no words.
- Full  output  1  FIFO holds DEPTH words.
- Count  output  log2(DEPTH)+1  number of words held.
- Underflow  output  1  sticky flag: a read occurred while empty.
- ClearErr  input  1  synchronous clear of Underflow.

Behaviour:
- Reset (Reset=0, asynchronous, any cycle): read and write pointers=0, Count=0, ReadData=EMPTY_VALUE, ReadValid=0, Underflow=0. Empty=1, Full=0, DevReady=1 follow from the state. Storage contents are don't-care.
- Reset mid-operation flushes all buffered words. No partially completed transfer survives.
- Outputs are derived from registered state only:
  - Empty = (Count==0).
  - Full = (Count==DEPTH).
  - DevReady = ~Full. It does not depend on ReadEn in the same cycle.
- Push: at a rising edge with DevValid & DevReady, DevData goes into mem[wptr], wptr increments modulo DEPTH, Count increments.
- Pop: at a rising edge with ReadEn & ~Empty:
  - ReadData <= mem[rptr]; ReadValid <= 1; rptr increments modulo DEPTH; Count decrements.
  - Read latency is 1 cycle: strobe in cycle N, data and ReadValid visible in cycle N+1.
- Read while empty: at a rising edge with ReadEn & Empty, ReadData <= EMPTY_VALUE, ReadValid <= 0, Underflow <= 1. Pointers and Count are unchanged.
- No read in a cycle: ReadValid <= 0 and ReadData holds its last value.
- Simultaneous push and pop with 0<Count<DEPTH: both happen and Count is unchanged.
- Full with ReadEn: pop only, because DevReady=0. DevReady rises in the next cycle.
- Empty with DevValid and ReadEn in the same cycle: no bypass. The read underflows and the word is pushed; Count becomes 1.
- Pointers wrap at DEPTH. Full and Empty are resolved by Count, not by pointer equality.
- Underflow clearing: ClearErr=1 clears Underflow at the edge. A new underflow in the same cycle wins, so Underflow stays 1.
- DevData is sampled only on a handshake edge. The device must hold DevData while DevValid=1 and DevReady=0.

Decomposition:
- Shared package holds:
  - IO_WIDTH = 16, the data word width.
  - IO_FIFO_DEPTH = 4, the FIFO depth.
  - IO_EMPTY_VALUE = 16'h0000, the empty-read value.
  - A log2 helper function used to size Count and the pointers.
- One sub-module: io_fifo_mem, a DEPTH x WIDTH register array.
  - Write port: WrEn, WrAddr, WrData.
  - Read port: combinational, addressed by RdAddr.
  - io_input_port owns the pointers, Count, flags and the ReadData register.

Test Plan:
- Assert Reset=0 mid-burst with Count=3 -> Count=0, Empty=1, DevReady=1, ReadData=16'h0000, ReadValid=0, Underflow=0, all immediately, without waiting for a clock edge.
- Push 16'h1111, 16'h2222, 16'h3333; strobe ReadEn for 3 consecutive cycles -> ReadData is 1111, 2222, 3333 on the following 3 cycles, ReadValid=1 each cycle; afterwards Empty=1.
- Push 5 words (A001..A005) with DevValid held high -> first 4 accepted, Full=1, DevReady=0, A005 held. One read returns A001, then A005 is accepted the next cycle. Draining returns A002..A005, which also exercises pointer wrap.
- Count=2; DevValid and ReadEn both high for 6 cycles with an incrementing DevData -> Count stays 2 and reads return words in push order.
- Empty; ReadEn=1 -> next cycle ReadData=16'h0000, ReadValid=0, Underflow=1, Count=0. Pulse ClearErr -> Underflow=0. ClearErr together with another empty read -> Underflow stays 1.
- Empty; DevValid=1 with DevData=16'hBEEF and ReadEn=1 in the same cycle -> read underflows, Count=1. The next read returns BEEF with ReadValid=1.
